// File: rtl/loadunit.sv
// loadunit: memory-stage load engine. Accepts one load, checks alignment,
// issues a single 64-bit bus read, extracts and sign/zero-extends the addressed
// lane, and holds the result until writeback takes it.
//
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   req_valid/req_ready             load request handshake (ready only in IDLE)
//   req_addr, req_msize             byte address and size (0=1B .. 3=8B)
//   req_unsigned, req_rd            zero-extend select, destination tag
//   dreq_valid/addr/size            bus read request, held until dresp_data_ok
//   dresp_data_ok, dresp_data       bus response beat (64-bit aligned)
//   rsp_valid/rsp_ready             result handshake to writeback
//   rsp_data, rsp_misalign, rsp_rd  extended result, misalign flag, echoed tag
module loadunit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_msize,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        dreq_valid,
  output logic [63:0] dreq_addr,
  output logic [1:0]  dreq_size,
  input  logic        dresp_data_ok,
  input  logic [63:0] dresp_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_misalign,
  output logic [4:0]  rsp_rd
);

  localparam int unsigned XLEN = 64;
  localparam int unsigned RD_W = 5;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUS  = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]      state, state_n;
  logic            uns_q, uns_n;
  logic [XLEN-1:0] addr_n;
  logic [1:0]      size_n;
  logic [RD_W-1:0] rd_n;
  logic [XLEN-1:0] data_n;
  logic            mis_n;
  logic            req_mis;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] extracted;

  // Alignment: the address must be a multiple of the access size.
  always_comb begin
    req_mis = 1'b0;
    case (req_msize)
      2'd1:    req_mis = req_addr[0];
      2'd2:    req_mis = |req_addr[1:0];
      2'd3:    req_mis = |req_addr[2:0];
      default: req_mis = 1'b0;
    endcase
  end

  // Lane extraction from the returned beat, using the captured address/size.
  always_comb begin
    shifted   = dresp_data >> {dreq_addr[2:0], 3'b000};
    extracted = shifted;
    case (dreq_size)
      2'd0: extracted = uns_q ? {56'd0, shifted[7:0]}
                              : {{56{shifted[7]}}, shifted[7:0]};
      2'd1: extracted = uns_q ? {48'd0, shifted[15:0]}
                              : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: extracted = uns_q ? {32'd0, shifted[31:0]}
                              : {{32{shifted[31]}}, shifted[31:0]};
      default: extracted = shifted;
    endcase
  end

  // Next-state and next-value logic.
  always_comb begin
    state_n = state;
    addr_n  = dreq_addr;
    size_n  = dreq_size;
    uns_n   = uns_q;
    rd_n    = rsp_rd;
    data_n  = rsp_data;
    mis_n   = rsp_misalign;
    case (state)
      IDLE: begin
        if (req_valid) begin
          addr_n  = req_addr;
          size_n  = req_msize;
          uns_n   = req_unsigned;
          rd_n    = req_rd;
          data_n  = '0;
          mis_n   = req_mis;
          state_n = req_mis ? RESP : BUS;
        end
      end
      BUS: begin
        if (dresp_data_ok) begin
          data_n  = extracted;
          state_n = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; handshake flags are registered decodes of the
  // next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      req_ready    <= 1'b1;
      dreq_valid   <= 1'b0;
      rsp_valid    <= 1'b0;
      dreq_addr    <= '0;
      dreq_size    <= '0;
      uns_q        <= 1'b0;
      rsp_rd       <= '0;
      rsp_data     <= '0;
      rsp_misalign <= 1'b0;
    end else begin
      state        <= state_n;
      req_ready    <= (state_n == IDLE);
      dreq_valid   <= (state_n == BUS);
      rsp_valid    <= (state_n == RESP);
      dreq_addr    <= addr_n;
      dreq_size    <= size_n;
      uns_q        <= uns_n;
      rsp_rd       <= rd_n;
      rsp_data     <= data_n;
      rsp_misalign <= mis_n;
    end
  end

endmodule

// File: tb/tb_loadunit.sv
// tb_loadunit: directed and randomized loads checked against an arithmetic
// reference model of lane extraction and alignment.
module tb_loadunit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [1:0]  req_msize;
  logic        req_unsigned;
  logic [4:0]  req_rd;
  logic        dreq_valid;
  logic [63:0] dreq_addr;
  logic [1:0]  dreq_size;
  logic        dresp_data_ok;
  logic [63:0] dresp_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_misalign;
  logic [4:0]  rsp_rd;

  int n_total = 0;
  int n_pass  = 0;

  loadunit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_msize(req_msize), .req_unsigned(req_unsigned), .req_rd(req_rd),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_misalign(rsp_misalign), .rsp_rd(rsp_rd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit model_mis(input logic [63:0] addr, input int size);
    return (addr % (64'd1 << size)) != 64'd0;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] addr, input int size,
                                             input bit uns, input logic [63:0] data);
    int nbits;
    logic [63:0] f, mask;
    f = data >> (8 * int'(addr % 64'd8));
    if (size == 3) return f;
    nbits = 8 << size;
    mask  = (64'd1 << nbits) - 64'd1;
    f     = f & mask;
    if (!uns && f[nbits-1]) f = f | ~mask;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete load: lat = cycles dreq_valid is high before data arrives,
  // bp = cycles rsp_ready is held low once the result is up.
  task automatic do_load(input logic [63:0] addr, input int size, input bit uns,
                         input logic [4:0] rd, input logic [63:0] data,
                         input int lat, input int bp);
    logic [63:0] exp;
    bit mis;
    mis = model_mis(addr, size);
    exp = mis ? 64'd0 : model_load(addr, size, uns, data);
    chk("req_ready_idle", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_addr = addr; req_msize = 2'(size);
    req_unsigned = uns; req_rd = rd;
    step();
    req_valid = 1'b0; req_addr = {$urandom, $urandom}; req_rd = 5'($urandom);
    if (!mis) begin
      for (int i = 1; i <= lat; i++) begin
        chk("dreq_valid_on", 64'(dreq_valid), 64'd1);
        chk("dreq_addr", dreq_addr, addr);
        chk("dreq_size", 64'(dreq_size), 64'(size));
        chk("rsp_valid_early", 64'(rsp_valid), 64'd0);
        dresp_data_ok = (i == lat);
        dresp_data    = (i == lat) ? data : {$urandom, $urandom};
        step();
        dresp_data_ok = 1'b0;
      end
    end
    chk("dreq_valid_off", 64'(dreq_valid), 64'd0);
    chk("rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rsp_misalign", 64'(rsp_misalign), 64'(mis));
    chk("rsp_data", rsp_data, exp);
    chk("rsp_rd", 64'(rsp_rd), 64'(rd));
    for (int i = 0; i < bp; i++) begin
      dresp_data_ok = 1'($urandom);
      dresp_data    = {$urandom, $urandom};
      step();
      dresp_data_ok = 1'b0;
      chk("rsp_valid_hold", 64'(rsp_valid), 64'd1);
      chk("rsp_data_hold", rsp_data, exp);
      chk("rsp_mis_hold", 64'(rsp_misalign), 64'(mis));
      chk("rsp_rd_hold", 64'(rsp_rd), 64'(rd));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
    chk("req_ready_back", 64'(req_ready), 64'd1);
  endtask

  initial begin
    logic [63:0] a;
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_msize = '0;
    req_unsigned = 1'b0; req_rd = '0; dresp_data_ok = 1'b0; dresp_data = '0;
    rsp_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_dreq_valid", 64'(dreq_valid), 64'd0);
    chk("rst_dreq_addr", dreq_addr, 64'd0);
    chk("rst_dreq_size", 64'(dreq_size), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data", rsp_data, 64'd0);
    chk("rst_rsp_misalign", 64'(rsp_misalign), 64'd0);
    chk("rst_rsp_rd", 64'(rsp_rd), 64'd0);

    // Directed cases.
    chk("lb_model", model_load(64'h8003, 0, 0, 64'h0000_0000_8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    do_load(64'h8003, 0, 0, 5'd3, 64'h0000_0000_8000_0000, 1, 0);
    do_load(64'h1004, 2, 1, 5'd7, 64'h89AB_CDEF_0123_4567, 1, 1);
    do_load(64'h1004, 2, 0, 5'd8, 64'h89AB_CDEF_0123_4567, 2, 0);
    do_load(64'h1001, 1, 0, 5'd9, 64'h0, 1, 0);
    do_load(64'h2000, 3, 0, 5'd10, 64'h0123_4567_89AB_CDEF, 3, 2);

    // Reset while the bus read is outstanding; the late response is dropped.
    req_valid = 1'b1; req_addr = 64'h3000; req_msize = 2'd3; req_rd = 5'd1;
    step();
    req_valid = 1'b0;
    chk("mid_bus_dreq", 64'(dreq_valid), 64'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_bus_dreq", 64'(dreq_valid), 64'd0);
    chk("rst_bus_ready", 64'(req_ready), 64'd1);
    dresp_data_ok = 1'b1; dresp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    step();
    dresp_data_ok = 1'b0;
    chk("late_ok_rsp", 64'(rsp_valid), 64'd0);
    chk("late_ok_ready", 64'(req_ready), 64'd1);
    do_load(64'h10, 1, 1, 5'd4, 64'h1234_5678_9ABC_FF80, 1, 0);

    // Randomized loads, biased toward aligned addresses.
    for (int n = 0; n < 60; n++) begin
      int sz;
      sz = $urandom_range(0, 3);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      do_load(a, sz, 1'($urandom), 5'($urandom), {$urandom, $urandom},
              $urandom_range(1, 4), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/loadunit.md
# loadunit

Memory-stage load engine: the read-side counterpart of the store-alignment logic. It accepts one load from the pipeline, checks alignment, and issues a single data-bus read. It then extracts the addressed byte, halfword, word or doubleword lane from the returned 64-bit beat, sign- or zero-extends it, and holds the result until writeback takes it. One load is in flight at a time; misaligned loads are reported without touching the bus.

## Interface
Parameters: none.

Ports:
- clk  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  load request from memory stage
- req_ready  out  1  high only in IDLE
- req_addr  in  64  byte address of load
- req_msize  in  2  0=1B, 1=2B, 2=4B, 3=8B
- req_unsigned  in  1  1: zero-extend (LBU/LHU/LWU); 0: sign-extend
- req_rd  in  5  destination register tag, returned unchanged
- dreq_valid  out  1  bus read request, held until dresp_data_ok
- dreq_addr  out  64  captured req_addr (low bits preserved)
- dreq_size  out  2  captured req_msize
- dresp_data_ok  in  1  bus data valid this cycle
- dresp_data  in  64  full 64-bit aligned beat containing the address
- rsp_valid  out  1  result available
- rsp_ready  in  1  writeback accepts result
- rsp_data  out  64  extended load result; 0 when misaligned
- rsp_misalign  out  1  load was misaligned; no bus access made
- rsp_rd  out  5  captured req_rd

## Operation
- States: IDLE, BUS, RESP.
- IDLE: req_ready=1. On req_valid, capture addr, msize, unsigned, rd.
  - Aligned: go to BUS.
  - Misaligned: go to RESP with rsp_misalign=1 and rsp_data=0.
- Misalignment rule:
  - msize=1 needs addr[0]=0.
  - msize=2 needs addr[1:0]=0.
  - msize=3 needs addr[2:0]=0.
  - msize=0 is never misaligned.
- BUS: dreq_valid=1; dreq_addr and dreq_size stay stable. On dresp_data_ok, register the extracted result and go to RESP.
- Extraction: shifted = dresp_data >> (addr[2:0]*8). Take the low 8/16/32/64 bits of shifted per msize. If unsigned, zero-extend to 64; otherwise replicate the MSB of the taken field. msize=3 passes through unchanged.
- RESP: rsp_valid=1. rsp_data, rsp_misalign and rsp_rd stay stable while rsp_ready=0. On rsp_ready, go to IDLE.
- dresp_data_ok outside BUS is ignored.
- Reset (any state): next state IDLE and all registered outputs cleared. A bus response arriving after reset is dropped.

## Timing
- State after reset: IDLE.
- Reset values:
  - req_ready=1.
  - dreq_valid=0, dreq_addr=0, dreq_size=0.
  - rsp_valid=0, rsp_data=0, rsp_misalign=0, rsp_rd=0.
- Request accepted in cycle T:
  - dreq_valid rises at T+1.
  - If dresp_data_ok arrives at cycle T+k (k≥1), rsp_valid rises at T+k+1.
  - Minimum load latency is 2 cycles.
- Misaligned request accepted at T: rsp_valid at T+1, and dreq_valid never asserts.
- rsp_valid and rsp_ready both high at cycle R: state is IDLE at R+1, so req_ready=1 at R+1. There is no same-cycle back-to-back accept; peak throughput is one load per 3 cycles.
- req_ready is a function of state only; it does not depend combinationally on req_valid.
- dreq_valid drops in the cycle after the dresp_data_ok cycle.
- Outputs are registered or decoded from state; there is no combinational path from dresp_data to rsp_data.

## Test plan
- LB sign-extend: addr=0x8003, msize=0, unsigned=0; data_ok one cycle after dreq_valid with data=0x0000_0000_8000_0000 -> rsp_data=0xFFFF_FFFF_FFFF_FF80, rsp_valid exactly 2 cycles after accept, rsp_misalign=0.
- LWU zero-extend: addr=0x1004, msize=2, unsigned=1, data=0x89AB_CDEF_0123_4567 -> rsp_data=0x0000_0000_89AB_CDEF. The same beat with unsigned=0 -> 0xFFFF_FFFF_89AB_CDEF.
- Misaligned LH: addr=0x1001, msize=1 -> dreq_valid stays 0; rsp_valid at T+1 with rsp_misalign=1, rsp_data=0, rsp_rd echoed.
- LD with bus wait and backpressure:
  - Stimulus: addr=0x2000, msize=3; dresp_data_ok 3 cycles after dreq_valid rises; data=0x0123_4567_89AB_CDEF; rsp_ready held low for 2 cycles.
  - Required: dreq_valid high exactly 3 cycles with dreq_addr and dreq_size stable; rsp_data=0x0123_4567_89AB_CDEF held stable while rsp_ready=0; req_ready=1 the cycle after rsp_ready rises.
- Reset mid-BUS:
  - Stimulus: assert reset for 1 cycle while in BUS, then pulse dresp_data_ok.
  - Required: dreq_valid=0 after reset; the late data_ok produces no rsp_valid; req_ready=1.
  - Follow-up: a new LHU at 0x10 with data byte lanes 1:0=0xFF80 -> 0x0000_0000_0000_FF80.
